// File: rtl/vcve2_lsu_arbiter.sv
// vcve2_lsu_arbiter
// Round-robin arbiter that shares the single vector LSU port among NumIfs
// VRF interface FSMs. One transaction is in flight at a time. Ownership is
// locked from grant until done. A watchdog forces release of a hung
// transaction and flags it on o-err.
//
// Handshake outputs (gnt_o, done_o, lsu_req_o, lsu_load_addr_o, err_o) are
// combinational from the current state and the LSU inputs. The LSU protocol
// needs grant and done to be reflected in the same cycle. busy_o and owner_o
// come straight from registers.

module vcve2_lsu_arbiter #(
  parameter int unsigned NumIfs        = 2,
  parameter int unsigned TimeoutCycles = 64,
  localparam int unsigned OwnerW = (NumIfs > 1) ? $clog2(NumIfs) : 1,
  localparam int unsigned CntW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumIfs-1:0] req_i,
  input  logic [NumIfs-1:0] load_addr_i,
  output logic [NumIfs-1:0] gnt_o,
  output logic [NumIfs-1:0] done_o,
  output logic              lsu_req_o,
  output logic              lsu_load_addr_o,
  input  logic              lsu_gnt_i,
  input  logic              lsu_done_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [OwnerW-1:0] owner_o,
  output logic              err_o
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // NumIfs held one bit wider than an index, so wrap compares cannot overflow
  localparam logic [OwnerW:0]   NUM_IFS_W = (OwnerW + 1)'(NumIfs);
  localparam logic [OwnerW:0]   ONE_W     = (OwnerW + 1)'(1);
  localparam logic [CntW-1:0]   CNT_MAX   = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0]   CNT_LAST  = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0]   CNT_ONE   = CntW'(1);
  localparam bit                WDOG_EN   = (TimeoutCycles != 0);

  // State registers
  logic [1:0]        state_q;
  logic [OwnerW-1:0] owner_q;
  logic [OwnerW-1:0] rr_ptr_q;
  logic [CntW-1:0]   cnt_q;

  // Next-state values
  logic [1:0]        w_state_d;
  logic [OwnerW-1:0] w_owner_d;
  logic [OwnerW-1:0] w_rr_ptr_d;
  logic [CntW-1:0]   w_cnt_d;

  // Arbitration helpers
  logic [NumIfs-1:0] w_owner_oh;
  logic              w_owner_req;
  logic              w_owner_la;
  logic [OwnerW-1:0] w_ptr_eff;
  logic [OwnerW:0]   w_cand;
  logic              w_hit;
  logic              w_sel_found;
  logic [OwnerW-1:0] w_sel_idx;
  logic [OwnerW:0]   w_ptr_sum;
  logic [OwnerW-1:0] w_ptr_next;
  logic              w_timeout;

  // Decode the owner index into a one-hot mask. This avoids variable part-selects.
  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < int'(NumIfs); i++) begin
      w_owner_oh[i] = (owner_q == OwnerW'(i));
    end
  end

  assign w_owner_req = |(req_i & w_owner_oh);
  assign w_owner_la  = |(load_addr_i & w_owner_oh);

  // A pointer outside 0..NumIfs-1 should never occur. Treat it as 0 so the scan stays legal.
  assign w_ptr_eff = ({1'b0, rr_ptr_q} < NUM_IFS_W) ? rr_ptr_q : '0;

  // Round-robin scan: take the first requester at or after the pointer, modulo NumIfs
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < int'(NumIfs); k++) begin
      w_cand = {1'b0, w_ptr_eff} + (OwnerW + 1)'(k);
      w_cand = (w_cand >= NUM_IFS_W) ? (w_cand - NUM_IFS_W) : w_cand;
      for (int j = 0; j < int'(NumIfs); j++) begin
        w_hit       = !w_sel_found && (w_cand == (OwnerW + 1)'(j)) && req_i[j];
        w_sel_idx   = w_hit ? OwnerW'(j) : w_sel_idx;
        w_sel_found = w_sel_found | w_hit;
      end
    end
  end

  // The pointer moves to the interface after the one that just completed
  assign w_ptr_sum  = {1'b0, owner_q} + ONE_W;
  assign w_ptr_next = (w_ptr_sum >= NUM_IFS_W) ? '0 : w_ptr_sum[OwnerW-1:0];

  // The watchdog fires in the TimeoutCycles-th BUSY cycle (cnt_q is 0 in the first)
  assign w_timeout = WDOG_EN && (cnt_q == CNT_LAST);

  // Next-state logic. Flush overrides every transition but keeps the owner and the pointer.
  always_comb begin
    w_state_d  = state_q;
    w_owner_d  = owner_q;
    w_rr_ptr_d = rr_ptr_q;
    w_cnt_d    = cnt_q;
    if (flush_i) begin
      w_state_d = ST_IDLE;
      w_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_sel_found) begin
            w_state_d = ST_REQ;
            w_owner_d = w_sel_idx;
          end else begin
            w_state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (lsu_gnt_i) begin
            w_state_d = ST_BUSY;
            w_cnt_d   = '0;
          end else if (!w_owner_req) begin
            w_state_d = ST_IDLE;
          end else begin
            w_state_d = ST_REQ;
          end
        end
        ST_BUSY: begin
          w_cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
          if (lsu_done_i || w_timeout) begin
            w_state_d  = ST_IDLE;
            w_rr_ptr_d = w_ptr_next;
          end else begin
            w_state_d = ST_BUSY;
          end
        end
        default: begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake outputs. Flush suppresses grant, done and error in its own cycle.
  always_comb begin
    gnt_o           = '0;
    done_o          = '0;
    lsu_req_o       = 1'b0;
    lsu_load_addr_o = 1'b0;
    err_o           = 1'b0;
    case (state_q)
      ST_REQ: begin
        lsu_req_o       = 1'b1;
        lsu_load_addr_o = w_owner_la;
        if (!flush_i && lsu_gnt_i) begin
          gnt_o = w_owner_oh;
        end else begin
          gnt_o = '0;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          done_o = '0;
        end else if (lsu_done_i) begin
          done_o = w_owner_oh;
        end else if (w_timeout) begin
          done_o = w_owner_oh;
          err_o  = 1'b1;
        end else begin
          done_o = '0;
        end
      end
      default: begin
        gnt_o = '0;
      end
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign owner_o = owner_q;

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= w_state_d;
      owner_q  <= w_owner_d;
      rr_ptr_q <= w_rr_ptr_d;
      cnt_q    <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_vcve2_lsu_arbiter.sv
// Testbench for vcve2_lsu_arbiter (NumIfs=3, TimeoutCycles=4).
// A cycle-by-cycle vector table drives the stimulus. Expected outputs are
// pushed to a scoreboard queue and compared at the falling edge. A
// hand-written sequence covers the asynchronous reset in REQ.

module tb_vcve2_lsu_arbiter;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [2:0] req_i;
  logic [2:0] load_addr_i;
  logic [2:0] gnt_o;
  logic [2:0] done_o;
  logic       lsu_req_o;
  logic       lsu_load_addr_o;
  logic       lsu_gnt_i;
  logic       lsu_done_i;
  logic       flush_i;
  logic       busy_o;
  logic [1:0] owner_o;
  logic       err_o;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] done;
    logic       lreq;
    logic       lla;
    logic       busy;
    logic [1:0] own;
    logic       err;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] la;
    logic       g;
    logic       d;
    logic       f;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  vcve2_lsu_arbiter #(
    .NumIfs       (3),
    .TimeoutCycles(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .load_addr_i    (load_addr_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .lsu_req_o      (lsu_req_o),
    .lsu_load_addr_o(lsu_load_addr_o),
    .lsu_gnt_i      (lsu_gnt_i),
    .lsu_done_i     (lsu_done_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] eg, input logic [2:0] ed, input logic elr,
                              input logic ella, input logic eb, input logic [1:0] eo,
                              input logic ee);
    exp_t e;
    e.gnt  = eg;
    e.done = ed;
    e.lreq = elr;
    e.lla  = ella;
    e.busy = eb;
    e.own  = eo;
    e.err  = ee;
    return e;
  endfunction

  task automatic add(input logic [2:0] req, input logic [2:0] la, input logic g, input logic d,
                     input logic f, input logic [2:0] eg, input logic [2:0] ed, input logic elr,
                     input logic ella, input logic eb, input logic [1:0] eo, input logic ee);
    vec_t v;
    v.req = req;
    v.la  = la;
    v.g   = g;
    v.d   = d;
    v.f   = f;
    v.e   = mk(eg, ed, elr, ella, eb, eo, ee);
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] la, input logic g,
                       input logic d, input logic f);
    req_i       = req;
    load_addr_i = la;
    lsu_gnt_i   = g;
    lsu_done_i  = d;
    flush_i     = f;
  endtask

  task automatic check(input string name);
    exp_t a;
    exp_t e;
    a = {gnt_o, done_o, lsu_req_o, lsu_load_addr_o, busy_o, owner_o, err_o};
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, actual outputs %b", name, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: actual gnt=%b done=%b lreq=%b lla=%b busy=%b own=%0d err=%b; required gnt=%b done=%b lreq=%b lla=%b busy=%b own=%0d err=%b",
                 name, a.gnt, a.done, a.lreq, a.lla, a.busy, a.own, a.err,
                 e.gnt, e.done, e.lreq, e.lla, e.busy, e.own, e.err);
      end
    end
  endtask

  initial begin
    // Single request: grant in the first REQ cycle, done in the second BUSY cycle
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    // Fairness: all requesting, LSU grants and finishes at once. The pointer is at 1.
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(3'b111, 3'b100, 1'b1, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    add(3'b111, 3'b100, 1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    // Withdraw: interface 1 drops its request in the second REQ cycle. The pointer stays at 1.
    add(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    // Timeout: 011 from pointer 1 picks 1. No done arrives; err fires in the 4th BUSY cycle.
    add(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    // Flush in BUSY with done high: no done, IDLE next, owner and pointer (2) kept
    add(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    // 011 from pointer 2 wraps to 0. lsu_done in REQ is ignored.
    add(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3'b011, 3'b001, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset phase
    rst_ni = 1'b0;
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    #3;
    sb.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    check("reset_hold");
    #9;
    rst_ni = 1'b1;
    #1;
    sb.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    check("after_reset");

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].req, tbl[i].la, tbl[i].g, tbl[i].d, tbl[i].f);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      check($sformatf("vec%0d", i));
    end

    // Asynchronous reset while in REQ. The pointer is at 1, so 110 selects owner 1.
    @(posedge clk);
    #1;
    drive(3'b110, 3'b000, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    check("rst_seq_idle");
    @(posedge clk);
    #1;
    drive(3'b110, 3'b010, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(3'b010, 3'b000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0));
    @(negedge clk);
    check("rst_seq_req");
    #1;
    rst_ni = 1'b0;
    #1;
    sb.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    check("async_rst_drop");
    #1;
    rst_ni = 1'b1;
    drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
    // After reset the pointer is 0, so 011 picks owner 0 rather than 1
    @(posedge clk);
    #1;
    sb.push_back(mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    @(negedge clk);
    check("rearb_ptr0");
    #1;
    drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    #1;
    check("rearb_gnt");
    @(posedge clk);
    #1;
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    sb.push_back(mk(3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0));
    @(negedge clk);
    check("rearb_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vcve2_lsu_arbiter.md
# vcve2_lsu_arbiter

Round-robin arbiter that shares the single vector LSU port (request/grant/done plus address-load strobe) among the `NumIfs` VRF interface FSMs. Today every VRF interface drives the LSU directly. This block sits between the VRF wrapper and the LSU. It serialises LSU transactions, locks ownership from grant until done, and releases a hung transaction with a watchdog timeout.

## Interface
- `NumIfs`, default 2: number of requesting VRF interfaces; legal values 1..3.
- `TimeoutCycles`, default 64: maximum cycles in BUSY before a forced release; 0 disables the watchdog.
- Derived `OwnerW` = max(1, $clog2(NumIfs)). Derived `CntW` = $clog2(TimeoutCycles+1).

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NumIfs  per-interface LSU request; held high until `gnt_o` for that interface.
- `load_addr_i`  in  NumIfs  per-interface address-load strobe, forwarded from the owner.
- `gnt_o`  out  NumIfs  per-interface grant; one-hot or zero.
- `done_o`  out  NumIfs  per-interface completion pulse; one-hot or zero.
- `lsu_req_o`  out  1  request to the LSU.
- `lsu_load_addr_o`  out  1  address-load strobe to the LSU.
- `lsu_gnt_i`  in  1  LSU grant.
- `lsu_done_i`  in  1  LSU transaction complete.
- `flush_i`  in  1  synchronous abort of any transaction in flight.
- `busy_o`  out  1  high while the state is REQ or BUSY.
- `owner_o`  out  OwnerW  index of the current or last owner.
- `err_o`  out  1  one-cycle pulse on a watchdog release.

## Operation
- FSM states: IDLE, REQ, BUSY. Registers: `state_q`, `owner_q`, `rr_ptr_q`, `cnt_q`.
- Reset values: `state_q`=IDLE, `owner_q`=0, `rr_ptr_q`=0, `cnt_q`=0. All outputs are 0 during and immediately after reset.
- IDLE:
  - If any `req_i` bit is set, select the first set bit scanning from `rr_ptr_q` upward, modulo NumIfs.
  - Latch the selected index into `owner_q` and go to REQ.
  - No outputs are asserted in IDLE.
- REQ:
  - `lsu_req_o`=1 and `lsu_load_addr_o`=`load_addr_i[owner_q]`.
  - `gnt_o[owner_q]`=`lsu_gnt_i`, combinational in the same cycle.
  - If `lsu_gnt_i`=1: go to BUSY and clear `cnt_q`.
  - Else if `req_i[owner_q]`=0: the requester withdrew; go to IDLE with the pointer unchanged.
  - `lsu_done_i` is ignored in REQ.
- BUSY:
  - `lsu_req_o`=0. `cnt_q` increments each cycle and saturates at TimeoutCycles.
  - If `lsu_done_i`=1: assert `done_o[owner_q]`=1 in the same cycle, set `rr_ptr_q`=(`owner_q`+1) mod NumIfs, and go to IDLE.
  - Else if TimeoutCycles≠0 and `cnt_q`==TimeoutCycles-1: assert `done_o[owner_q]`=1 and `err_o`=1, update the pointer as for a normal done, and go to IDLE.
- `flush_i`:
  - Has priority over every transition.
  - Next state is IDLE, `cnt_q` is cleared, and `rr_ptr_q` and `owner_q` keep their values.
  - No `gnt_o`, `done_o` or `err_o` is generated in the flush cycle, even if `lsu_gnt_i` or `lsu_done_i` is high.
- `owner_o`=`owner_q` at all times. `busy_o`=(state != IDLE).
- NumIfs=1: the arbitration is trivial and `owner_o` is constantly 0.
- Out-of-range pointer wrap: with NumIfs=3 the pointer sequence is 0→1→2→0. A pointer value of 3 is unreachable; if it is ever seen it is treated as 0.

## Timing
- Arbitration latency: `req_i` seen in cycle N in IDLE gives `lsu_req_o`=1 in cycle N+1.
- Minimum transaction length is 3 cycles (IDLE→REQ→BUSY) when `lsu_gnt_i` arrives in the first REQ cycle and `lsu_done_i` in the first BUSY cycle.
- At least one IDLE cycle separates consecutive transactions, so back-to-back throughput is one transaction per 3 cycles.
- A request arriving while the state is REQ or BUSY waits; there is no preemption.
- Watchdog: `err_o` fires in the TimeoutCycles-th BUSY cycle, counted from the first BUSY cycle.
- Reset asserted mid-transaction: all outputs drop immediately (asynchronous) and the state is IDLE after release.

## Test plan
- Single request: `req_i`=01 at cycle 0, `lsu_gnt_i` at cycle 1, `lsu_done_i` at cycle 3 → `lsu_req_o` high only in cycle 1; `gnt_o`=01 in cycle 1; `done_o`=01 in cycle 3; `rr_ptr` becomes 1.
- Fairness with NumIfs=3: `req_i`=111 held constant, LSU grants and finishes immediately → owners granted in order 0,1,2,0, each grant 3 cycles apart.
- Withdraw: `req_i`=10, `lsu_gnt_i` held low, `req_i[1]` dropped in the second REQ cycle → IDLE next cycle; no `gnt_o`; `rr_ptr` stays 0.
- Timeout with TimeoutCycles=4: grant given, `lsu_done_i` never asserted → `err_o` and `done_o[owner]` pulse in the 4th BUSY cycle; `busy_o` is 0 in the following cycle.
- Flush: `flush_i` pulsed in a BUSY cycle while `lsu_done_i`=1 → no `done_o`; state IDLE next cycle; `owner_o` unchanged.
- Asynchronous reset pulse during REQ → `lsu_req_o`, `gnt_o` and `busy_o` go to 0 without waiting for a clock edge; after release `req_i`=01 is re-arbitrated starting from pointer 0.
